// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and protocol constants for the UART-to-memory command bridge.
package uart_mem_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_DATA,
      S_REQ,
      S_WAIT_RSP,
      S_RESP,
      S_NAK
   } state_e;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   // Serializer load word: number of bytes to send (1..4) and the bytes, MSB first.
   typedef struct packed {
      logic [2:0]  count;
      logic [31:0] word;
   } ser_load_t;

endpackage

// File: rtl/uart_mem_bridge_resp_ser.sv
// Response serializer: sends 1..4 bytes MSB first over a valid/ready handshake.
module uart_mem_bridge_resp_ser
   import uart_mem_bridge_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  ser_load_t  load_data_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic       done_o
);

   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;

   // Load a new response, or shift out one byte per accepted handshake.
   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (load_i) begin
         cnt_d  = load_data_i.count;
         word_d = load_data_i.word;
      end else if (tx_valid_o && tx_ready_i) begin
         cnt_d  = cnt_q - 3'd1;
         word_d = {word_q[23:0], 8'h00};
      end
   end

   // Byte counter and shift register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 3'd0;
         word_q <= 32'h0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign tx_valid_o = (cnt_q != 3'd0);
   assign tx_data_o  = word_q[31:24];
   // Pulses on the handshake of the last byte of the response.
   assign done_o     = tx_valid_o && tx_ready_i && (cnt_q == 3'd1);

endmodule

// File: rtl/uart_mem_bridge.sv
// Decodes UART byte packets into 32-bit memory reads/writes and returns ACK/NAK/data.
module uart_mem_bridge
   import uart_mem_bridge_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   input  logic              rx_frame_err_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              data_req_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [31:0]       data_wdata_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i,
   input  logic              err_clr_i,
   output logic              recv_error_o,
   output logic              busy_o
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d;

   logic              err_set;
   logic              ser_load;
   ser_load_t         ser_load_data;
   logic              ser_done;
   logic              collecting;
   logic              tmo_hit;
   logic              abort;
   logic [15:0]       addr16;
   logic              addr_bad;

   assign collecting = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);
   assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   // A framing error or an inter-byte timeout kills a packet still being collected.
   assign abort      = rx_frame_err_i || (!rx_valid_i && tmo_hit);
   assign addr16     = {addr_hi_q, rx_data_i};
   assign addr_bad   = ((addr16 >> ADDR_W) != 16'd0) || (addr16[1:0] != 2'b00);

   // Next-state, packet assembly, error detection and response loading.
   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      addr_hi_d     = addr_hi_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      byte_cnt_d    = byte_cnt_q;
      tmo_d         = (rx_valid_i || !collecting) ? '0 : tmo_q + TMO_W'(1);
      err_set       = rx_frame_err_i;
      ser_load      = 1'b0;
      ser_load_data = '{count: 3'd1, word: {RSP_NAK, 24'h0}};

      unique case (state_q)
         S_IDLE: begin
            if (rx_valid_i) begin
               if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                  we_d    = (rx_data_i == CMD_WRITE);
                  state_d = S_ADDR_HI;
               end else begin
                  err_set  = 1'b1;
                  ser_load = 1'b1;
                  state_d  = S_NAK;
               end
            end
         end
         S_ADDR_HI: begin
            if (abort) begin
               err_set = 1'b1;
               state_d = S_IDLE;
            end else if (rx_valid_i) begin
               addr_hi_d = rx_data_i;
               state_d   = S_ADDR_LO;
            end
         end
         S_ADDR_LO: begin
            if (abort) begin
               err_set = 1'b1;
               state_d = S_IDLE;
            end else if (rx_valid_i) begin
               if (addr_bad) begin
                  err_set  = 1'b1;
                  ser_load = 1'b1;
                  state_d  = S_NAK;
               end else begin
                  addr_d     = addr16[ADDR_W-1:0];
                  byte_cnt_d = 2'd0;
                  state_d    = we_q ? S_DATA : S_REQ;
               end
            end
         end
         S_DATA: begin
            if (abort) begin
               err_set = 1'b1;
               state_d = S_IDLE;
            end else if (rx_valid_i) begin
               wdata_d    = {wdata_q[23:0], rx_data_i};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (rx_valid_i) err_set = 1'b1;
            if (data_gnt_i) state_d = S_WAIT_RSP;
         end
         S_WAIT_RSP: begin
            if (rx_valid_i) err_set = 1'b1;
            if (data_rvalid_i) begin
               ser_load = 1'b1;
               if (we_q) ser_load_data = '{count: 3'd1, word: {RSP_ACK, 24'h0}};
               else      ser_load_data = '{count: 3'd4, word: data_rdata_i};
               state_d = S_RESP;
            end
         end
         S_RESP, S_NAK: begin
            if (rx_valid_i) err_set = 1'b1;
            if (ser_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A new error takes precedence over a coincident clear.
      err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         addr_hi_q  <= 8'h0;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         byte_cnt_q <= 2'd0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_hi_q  <= addr_hi_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
      end
   end

   uart_mem_bridge_resp_ser u_resp_ser (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (ser_load),
      .load_data_i (ser_load_data),
      .tx_data_o   (tx_data_o),
      .tx_valid_o  (tx_valid_o),
      .tx_ready_i  (tx_ready_i),
      .done_o      (ser_done)
   );

   assign data_req_o   = (state_q == S_REQ);
   assign data_we_o    = we_q;
   // Full-word accesses only; enables are qualified by the request so they read 0 when idle.
   assign data_be_o    = data_req_o ? 4'hF : 4'h0;
   assign data_addr_o  = addr_q;
   assign data_wdata_o = wdata_q;
   assign recv_error_o = err_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: packet-level reference model, RAM responder, monitor.
`timescale 1ns/1ps
module tb_uart_mem_bridge;
   import uart_mem_bridge_pkg::*;

   localparam int ADDR_W = 12;
   localparam int TMO    = 16;

   logic              clk_i, rst_i;
   logic [7:0]        rx_data_i;
   logic              rx_valid_i, rx_frame_err_i;
   logic [7:0]        tx_data_o;
   logic              tx_valid_o, tx_ready_i;
   logic              data_req_o, data_we_o;
   logic [3:0]        data_be_o;
   logic [ADDR_W-1:0] data_addr_o;
   logic [31:0]       data_wdata_o;
   logic              data_gnt_i, data_rvalid_i;
   logic [31:0]       data_rdata_i;
   logic              err_clr_i, recv_error_o, busy_o;

   uart_mem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_frame_err_i(rx_frame_err_i),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
      .err_clr_i(err_clr_i), .recv_error_o(recv_error_o), .busy_o(busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   int          tests = 0;
   int          fails = 0;
   req_t        exp_req_q[$];
   logic [7:0]  exp_tx_q[$];
   logic [7:0]  pkt_q[$];
   logic [31:0] mem_model [0:1023];
   logic [31:0] ram [0:1023];
   logic        err_exp = 1'b0;
   int          rdy_mode = 0;
   int          gnt_dly_fixed = -1;
   int          rv_dly_fixed = -1;
   bit          gnt_hold = 1'b0;
   int          inject_req = 0;
   int          inject_done = 0;
   int          gnt_wait = -1;
   int          rv_wait = 0;
   logic [31:0] rd_word = 32'h0;

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'h12345678;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RAM responder: random grant latency, rvalid 1..3 cycles after grant.
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = init_word(i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      forever begin
         @(negedge clk_i);
         data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
         if (rst_i) begin
            gnt_wait = -1; rv_wait = 0;
         end else if (inject_req != inject_done) begin
            data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0BAD0; inject_done++;
         end else if (rv_wait > 0) begin
            rv_wait--;
            if (rv_wait == 0) begin data_rvalid_i = 1'b1; data_rdata_i = rd_word; end
         end else if (data_req_o && !gnt_hold) begin
            if (gnt_wait < 0) gnt_wait = (gnt_dly_fixed >= 0) ? gnt_dly_fixed : int'($urandom_range(0, 3));
            if (gnt_wait == 0) begin
               data_gnt_i = 1'b1; gnt_wait = -1;
               if (data_we_o) ram[data_addr_o[11:2]] = data_wdata_o;
               else           rd_word = ram[data_addr_o[11:2]];
               rv_wait = (rv_dly_fixed > 0) ? rv_dly_fixed : int'($urandom_range(1, 3));
            end else gnt_wait--;
         end
      end
   end

   // Transmitter ready: 0 = always ready, 1 = toggling, 2 = random.
   initial begin
      tx_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         case (rdy_mode)
            0:       tx_ready_i = 1'b1;
            1:       tx_ready_i = ~tx_ready_i;
            default: tx_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on every granted request and every accepted tx byte.
   initial begin
      req_t e;
      logic [7:0] b;
      forever begin
         @(negedge clk_i);
         #2;
         if (!rst_i) begin
            if (data_req_o && data_gnt_i) begin
               $display("[TB] mem req we=%0d addr=%h wdata=%h be=%h", data_we_o, data_addr_o, data_wdata_o, data_be_o);
               if (exp_req_q.size() == 0) chk("unexpected_req", 32'(data_addr_o), 32'hFFFFFFFF);
               else begin
                  e = exp_req_q.pop_front();
                  chk("req_we", 32'(data_we_o), 32'(e.we));
                  chk("req_addr", 32'(data_addr_o), 32'(e.addr));
                  chk("req_be", 32'(data_be_o), 32'hF);
                  if (e.we) chk("req_wdata", data_wdata_o, e.wdata);
               end
            end
            if (tx_valid_o && tx_ready_i) begin
               $display("[TB] tx byte %h", tx_data_o);
               if (exp_tx_q.size() == 0) chk("unexpected_tx", 32'(tx_data_o), 32'hFFFFFFFF);
               else begin
                  b = exp_tx_q.pop_front();
                  chk("tx_byte", 32'(tx_data_o), 32'(b));
               end
            end
         end
      end
   end

   // Reference model: decides the whole packet outcome from its bytes.
   task automatic model_packet();
      logic [15:0] a;
      logic [31:0] w;
      int          idx;
      if (pkt_q[0] != CMD_WRITE && pkt_q[0] != CMD_READ) begin
         exp_tx_q.push_back(RSP_NAK); err_exp = 1'b1; return;
      end
      a = {pkt_q[1], pkt_q[2]};
      if (int'(a) >= (1 << ADDR_W) || (a % 4) != 0) begin
         exp_tx_q.push_back(RSP_NAK); err_exp = 1'b1; return;
      end
      idx = int'(a) / 4;
      if (pkt_q[0] == CMD_WRITE) begin
         w = {pkt_q[3], pkt_q[4], pkt_q[5], pkt_q[6]};
         mem_model[idx] = w;
         exp_req_q.push_back('{we: 1'b1, addr: a[ADDR_W-1:0], wdata: w});
         exp_tx_q.push_back(RSP_ACK);
      end else begin
         w = mem_model[idx];
         exp_req_q.push_back('{we: 1'b0, addr: a[ADDR_W-1:0], wdata: 32'h0});
         for (int k = 3; k >= 0; k--) exp_tx_q.push_back(w[8*k +: 8]);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk_i);
      rx_data_i = b; rx_valid_i = 1'b1;
      @(negedge clk_i);
      rx_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         if (!busy_o) begin ok = 1'b1; break; end
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic run_packet(input int gap_max);
      model_packet();
      foreach (pkt_q[i]) begin
         repeat ($urandom_range(0, gap_max)) @(negedge clk_i);
         send_byte(pkt_q[i]);
      end
      wait_idle("pkt_done");
      chk("recv_error", 32'(recv_error_o), 32'(err_exp));
   endtask

   task automatic set_pkt3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      pkt_q.delete();
      pkt_q.push_back(b0); pkt_q.push_back(b1); pkt_q.push_back(b2);
   endtask

   task automatic pulse_clr();
      @(negedge clk_i); err_clr_i = 1'b1;
      @(negedge clk_i); err_clr_i = 1'b0;
      err_exp = 1'b0;
   endtask

   task automatic check_quiet_outputs(input string tag);
      chk({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
      chk({tag, "_req"}, 32'(data_req_o), 32'd0);
      chk({tag, "_we"}, 32'(data_we_o), 32'd0);
      chk({tag, "_be"}, 32'(data_be_o), 32'd0);
      chk({tag, "_addr"}, 32'(data_addr_o), 32'd0);
      chk({tag, "_wdata"}, data_wdata_o, 32'd0);
      chk({tag, "_err"}, 32'(recv_error_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a16;
      logic [31:0] w;
      logic [7:0]  c;
      bit          seen;
      for (int i = 0; i < 1024; i++) mem_model[i] = init_word(i);
      rst_i = 1'b1; rx_data_i = 8'h0; rx_valid_i = 1'b0; rx_frame_err_i = 1'b0; err_clr_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_quiet_outputs("reset");
      rst_i = 1'b0;

      // Read with toggling ready.
      rdy_mode = 1;
      set_pkt3(CMD_READ, 8'h00, 8'h40);
      run_packet(0);
      chk("read_busy_after", 32'(busy_o), 32'd0);

      // Write with fixed grant latency.
      rdy_mode = 0; gnt_dly_fixed = 2;
      pkt_q.delete();
      pkt_q.push_back(CMD_WRITE); pkt_q.push_back(8'h00); pkt_q.push_back(8'h40);
      pkt_q.push_back(8'hDE); pkt_q.push_back(8'hAD); pkt_q.push_back(8'hBE); pkt_q.push_back(8'hEF);
      run_packet(0);
      gnt_dly_fixed = -1;

      // Bad command, out-of-range address, misaligned address.
      pkt_q.delete(); pkt_q.push_back(8'h41);
      run_packet(0);
      pulse_clr();
      chk("err_cleared", 32'(recv_error_o), 32'd0);
      set_pkt3(CMD_READ, 8'h10, 8'h00);
      run_packet(0);
      set_pkt3(CMD_READ, 8'h00, 8'h02);
      run_packet(0);

      // Inter-byte timeout.
      pulse_clr();
      send_byte(CMD_WRITE);
      send_byte(8'h00);
      repeat (15) @(negedge clk_i);
      chk("tmo_still_busy", 32'(busy_o), 32'd1);
      chk("tmo_err_not_yet", 32'(recv_error_o), 32'd0);
      @(negedge clk_i);
      chk("tmo_idle", 32'(busy_o), 32'd0);
      chk("tmo_err", 32'(recv_error_o), 32'd1);
      err_exp = 1'b1;
      set_pkt3(CMD_READ, 8'h00, 8'h00);
      run_packet(0);

      // Overrun during WAIT_RSP.
      pulse_clr();
      rv_dly_fixed = 6;
      set_pkt3(CMD_READ, 8'h00, 8'h08);
      model_packet();
      foreach (pkt_q[i]) send_byte(pkt_q[i]);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (!data_req_o) begin seen = 1'b1; break; end
      end
      chk("ovr_req_done", 32'(seen), 32'd1);
      send_byte(8'hAA);
      err_exp = 1'b1;
      wait_idle("ovr_done");
      chk("ovr_err", 32'(recv_error_o), 32'd1);
      rv_dly_fixed = -1;

      // Frame error mid-packet, then clear coincident with a frame error.
      pulse_clr();
      send_byte(CMD_WRITE);
      @(negedge clk_i); rx_frame_err_i = 1'b1;
      @(negedge clk_i); rx_frame_err_i = 1'b0;
      chk("ferr_idle", 32'(busy_o), 32'd0);
      chk("ferr_err", 32'(recv_error_o), 32'd1);
      pulse_clr();
      chk("ferr_cleared", 32'(recv_error_o), 32'd0);
      @(negedge clk_i); rx_frame_err_i = 1'b1; err_clr_i = 1'b1;
      @(negedge clk_i); rx_frame_err_i = 1'b0; err_clr_i = 1'b0;
      chk("err_wins_clr", 32'(recv_error_o), 32'd1);
      err_exp = 1'b1;

      // Reset while a request waits for grant; a late rvalid must be ignored.
      gnt_hold = 1'b1;
      pkt_q.delete();
      pkt_q.push_back(CMD_WRITE); pkt_q.push_back(8'h00); pkt_q.push_back(8'h10);
      pkt_q.push_back(8'h01); pkt_q.push_back(8'h02); pkt_q.push_back(8'h03); pkt_q.push_back(8'h04);
      foreach (pkt_q[i]) send_byte(pkt_q[i]);
      chk("rst_req_pending", 32'(data_req_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      check_quiet_outputs("midreset");
      rst_i = 1'b0; err_exp = 1'b0; gnt_hold = 1'b0;
      inject_req++;
      repeat (4) @(negedge clk_i);
      chk("late_rvalid_busy", 32'(busy_o), 32'd0);
      chk("late_rvalid_tx", 32'(tx_valid_o), 32'd0);

      // Randomized packets against the reference model.
      rdy_mode = 2;
      for (int n = 0; n < 40; n++) begin
         int kind = int'($urandom_range(0, 4));
         int idx  = int'($urandom_range(0, 1023));
         a16 = 16'(idx * 4);
         c   = $urandom_range(0, 1) != 0 ? CMD_WRITE : CMD_READ;
         case (kind)
            0: begin
               w = $urandom;
               set_pkt3(CMD_WRITE, a16[15:8], a16[7:0]);
               pkt_q.push_back(w[31:24]); pkt_q.push_back(w[23:16]);
               pkt_q.push_back(w[15:8]);  pkt_q.push_back(w[7:0]);
            end
            1: set_pkt3(CMD_READ, a16[15:8], a16[7:0]);
            2: begin
               c = 8'($urandom_range(0, 255));
               if (c == CMD_WRITE || c == CMD_READ) c = 8'h00;
               pkt_q.delete(); pkt_q.push_back(c);
            end
            3: begin
               a16[15:12] = 4'($urandom_range(1, 15));
               set_pkt3(c, a16[15:8], a16[7:0]);
            end
            default: begin
               a16 = a16 + 16'($urandom_range(1, 3));
               set_pkt3(c, a16[15:8], a16[7:0]);
            end
         endcase
         run_packet(3);
         if ($urandom_range(0, 2) == 0) pulse_clr();
      end

      repeat (5) @(negedge clk_i);
      chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
      chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
